// File: rtl/texture_sampler.sv
// texture_sampler: point-sampling texture unit with repeat addressing.
// Converts a Q16.16 (u, v) lookup into a texel byte address, reads one
// RGBA8888 word over a ready/valid memory port and returns four
// zero-extended channels with a one-cycle valid pulse.
// Optional: define TEX_CACHE_EN to build a single-entry texel cache.
module texture_sampler #(
  parameter int DATA_WIDTH = 32,
  parameter int VEC_SIZE   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TEX_W_LOG2 = 6,
  parameter int TEX_H_LOG2 = 6,
  parameter logic [ADDR_WIDTH-1:0] TEX_BASE = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_tex_req_valid,
  output logic                                 o_tex_req_ready,
  input  logic [DATA_WIDTH-1:0]                i_tex_u_coord,
  input  logic [DATA_WIDTH-1:0]                i_tex_v_coord,
  output logic                                 o_texel_valid,
  output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  o_texel_color,
  output logic                                 o_mem_req_valid,
  input  logic                                 i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  input  logic                                 i_mem_rvalid,
  input  logic [31:0]                          i_mem_rdata,
  input  logic                                 i_cache_inval
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;
  state_t state;

  localparam int OFF_W = TEX_W_LOG2 + TEX_H_LOG2 + 2;

  // Only the top fraction bits select the texel; dropping the integer part wraps.
  logic [TEX_W_LOG2-1:0]  tx;
  logic [TEX_H_LOG2-1:0]  ty;
  logic [OFF_W-1:0]       texel_off;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   hit;

  assign tx        = i_tex_u_coord[15 -: TEX_W_LOG2];
  assign ty        = i_tex_v_coord[15 -: TEX_H_LOG2];
  // (y << W) + x is just the concatenation {y, x}; two zero bits scale by 4 bytes.
  assign texel_off = {ty, tx, 2'b00};
  assign req_addr  = TEX_BASE + ADDR_WIDTH'(texel_off);

  // Per-channel unpack of the RGBA8888 word, channel 0 in the low byte.
  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] unpacked;
  for (genvar k = 0; k < VEC_SIZE; k++) begin : g_unpack
    assign unpacked[k] = DATA_WIDTH'(i_mem_rdata[8*k +: 8]);
  end

  // Coordinate bits outside the texel selection carry no information here.
  logic unused_bits;
  assign unused_bits = ^{i_tex_u_coord, i_tex_v_coord, i_cache_inval};

`ifdef TEX_CACHE_EN
  // The cached color is o_texel_color itself: only fetches update it and a
  // hit returns it unchanged, so it always holds the data for the tag.
  logic [ADDR_WIDTH-1:0] tag;
  logic                  tag_vld;

  assign hit = tag_vld && (tag == req_addr);

  // Tag refill on fetch completion; invalidate is ordered last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag     <= '0;
      tag_vld <= 1'b0;
    end else begin
      if (state == WAIT && i_mem_rvalid) begin
        tag     <= o_mem_addr;
        tag_vld <= 1'b1;
      end
      if (i_cache_inval) tag_vld <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Request FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      o_tex_req_ready <= 1'b1;
      o_mem_req_valid <= 1'b0;
      o_mem_addr      <= '0;
      o_texel_valid   <= 1'b0;
      o_texel_color   <= '0;
    end else begin
      case (state)
        IDLE: if (i_tex_req_valid) begin
          o_mem_addr      <= req_addr;
          o_tex_req_ready <= 1'b0;
          if (hit) begin
            o_texel_valid <= 1'b1;
            state         <= RESP;
          end else begin
            o_mem_req_valid <= 1'b1;
            state           <= ADDR;
          end
        end
        // Read data during the request handshake is not ours yet.
        ADDR: if (i_mem_req_ready) begin
          o_mem_req_valid <= 1'b0;
          state           <= WAIT;
        end
        WAIT: if (i_mem_rvalid) begin
          o_texel_color <= unpacked;
          o_texel_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          o_texel_valid   <= 1'b0;
          o_tex_req_ready <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_texture_sampler.sv
// tb_texture_sampler: directed vectors for texture_sampler address/unpack,
// latency, stalls, stray read data and mid-transaction reset.
module tb_texture_sampler;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_tex_req_valid;
  logic               o_tex_req_ready;
  logic [31:0]        i_tex_u_coord;
  logic [31:0]        i_tex_v_coord;
  logic               o_texel_valid;
  logic [3:0][31:0]   o_texel_color;
  logic               o_mem_req_valid;
  logic               i_mem_req_ready;
  logic [31:0]        o_mem_addr;
  logic               i_mem_rvalid;
  logic [31:0]        i_mem_rdata;
  logic               i_cache_inval;

  int total = 0;
  int bad   = 0;

  texture_sampler dut (
    .clk(clk), .rst_n(rst_n),
    .i_tex_req_valid(i_tex_req_valid), .o_tex_req_ready(o_tex_req_ready),
    .i_tex_u_coord(i_tex_u_coord), .i_tex_v_coord(i_tex_v_coord),
    .o_texel_valid(o_texel_valid), .o_texel_color(o_texel_color),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .i_cache_inval(i_cache_inval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  u;
    logic [31:0]  v;
    logic [31:0]  rdata;
    logic [31:0]  addr;
    logic [127:0] color;
  } vec_t;
  vec_t tv[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic inval();
    i_cache_inval = 1'b1;
    tick();
    i_cache_inval = 1'b0;
  endtask

  // Zero-wait miss: accept at t, mem req at t+1, rvalid at t+2, texel at t+3.
  task automatic miss_req(input vec_t t);
    tick();
    i_tex_req_valid = 1'b1; i_tex_u_coord = t.u; i_tex_v_coord = t.v;
    chk("req_ready", o_tex_req_ready, 1'b1);
    tick();
    i_tex_req_valid = 1'b0;
    chk("mem_req_t1", o_mem_req_valid, 1'b1);
    chk("mem_addr", o_mem_addr, t.addr);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    chk("mem_req_drop_t2", o_mem_req_valid, 1'b0);
    chk("no_texel_t2", o_texel_valid, 1'b0);
    i_mem_rvalid = 1'b1; i_mem_rdata = t.rdata;
    tick();
    i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    chk("texel_valid_t3", o_texel_valid, 1'b1);
    chk("texel_color", o_texel_color, t.color);
    tick();
    chk("texel_pulse_end_t4", o_texel_valid, 1'b0);
    chk("ready_back_t4", o_tex_req_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; i_tex_req_valid = 1'b0; i_tex_u_coord = '0; i_tex_v_coord = '0;
    i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_cache_inval = 1'b0;

    tv[0] = '{32'h0000_8000, 32'h0001_4000, 32'h80FF_1020, 32'h0000_1080,
              {32'h80, 32'hFF, 32'h10, 32'h20}};
    tv[1] = '{32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000,
              {32'h12, 32'h34, 32'h56, 32'h78}};
    tv[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_3FFC,
              {32'hFF, 32'hFF, 32'hFF, 32'hFF}};
    tv[3] = '{32'h0003_0400, 32'h0002_0C00, 32'hDEAD_BEEF, 32'h0000_0304,
              {32'hDE, 32'hAD, 32'hBE, 32'hEF}};
    tv[4] = '{32'h0000_FC00, 32'h0000_0000, 32'h0000_0001, 32'h0000_00FC,
              {32'h00, 32'h00, 32'h00, 32'h01}};

    // Reset state, during and just after reset.
    tick(); tick(); tick();
    chk("rst_ready", o_tex_req_ready, 1'b1);
    chk("rst_texel_valid", o_texel_valid, 1'b0);
    chk("rst_mem_req", o_mem_req_valid, 1'b0);
    chk("rst_color", o_texel_color, 128'h0);
    chk("rst_addr", o_mem_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", o_tex_req_ready, 1'b1);
    chk("post_rst_mem_req", o_mem_req_valid, 1'b0);

    // Address/wrap/unpack vectors over zero-wait memory.
    for (int i = 0; i < 5; i++) miss_req(tv[i]);

    // Stray rvalid in IDLE: no texel, color retained.
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAAAA_AAAA;
    tick();
    i_mem_rvalid = 1'b0;
    chk("idle_stray_valid", o_texel_valid, 1'b0);
    chk("idle_stray_color", o_texel_color, tv[4].color);
    chk("idle_stray_ready", o_tex_req_ready, 1'b1);

    // 3-cycle request stall, stray rvalid in ADDR and in the handshake cycle.
    inval();
    tick();
    i_tex_req_valid = 1'b1; i_tex_u_coord = tv[3].u; i_tex_v_coord = tv[3].v;
    tick();                                   // t+1
    i_tex_req_valid = 1'b0;
    chk("stall_addr", o_mem_addr, tv[3].addr);
    tick();                                   // t+2
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_5555;
    tick();                                   // t+3
    i_mem_rvalid = 1'b0;
    chk("stall_hold_req", o_mem_req_valid, 1'b1);
    chk("stall_no_texel", o_texel_valid, 1'b0);
    tick();                                   // t+4
    i_mem_req_ready = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h6666_6666;
    tick();                                   // t+5
    i_mem_req_ready = 1'b0; i_mem_rdata = tv[3].rdata;
    chk("stall_no_texel_t5", o_texel_valid, 1'b0);
    chk("stall_req_drop_t5", o_mem_req_valid, 1'b0);
    tick();                                   // t+6
    i_mem_rvalid = 1'b0;
    chk("stall_texel_t6", o_texel_valid, 1'b1);
    chk("stall_color", o_texel_color, tv[3].color);
    tick();
    chk("stall_pulse_end", o_texel_valid, 1'b0);
    chk("stall_ready_back", o_tex_req_ready, 1'b1);

    // Reset while in WAIT; the late rvalid must not produce a texel.
    inval();
    tick();
    i_tex_req_valid = 1'b1; i_tex_u_coord = tv[1].u; i_tex_v_coord = tv[1].v;
    tick();
    i_tex_req_valid = 1'b0; i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    chk("pre_rst_wait_ready", o_tex_req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", o_tex_req_ready, 1'b1);
    chk("midrst_mem_req", o_mem_req_valid, 1'b0);
    chk("midrst_color", o_texel_color, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = tv[1].rdata;
    tick();
    i_mem_rvalid = 1'b0;
    chk("late_rvalid_valid", o_texel_valid, 1'b0);
    chk("late_rvalid_color", o_texel_color, 128'h0);
    tick();
    chk("late_rvalid_valid2", o_texel_valid, 1'b0);
    chk("late_rvalid_ready", o_tex_req_ready, 1'b1);

    // Clean transaction after the abandoned one.
    miss_req(tv[0]);

`ifdef TEX_CACHE_EN
    // Second identical request hits: texel at t+1 and no memory request.
    miss_req(tv[2]);
    tick();
    i_tex_req_valid = 1'b1; i_tex_u_coord = tv[2].u; i_tex_v_coord = tv[2].v;
    tick();
    i_tex_req_valid = 1'b0;
    chk("hit_texel_t1", o_texel_valid, 1'b1);
    chk("hit_no_mem_req", o_mem_req_valid, 1'b0);
    chk("hit_color", o_texel_color, tv[2].color);
    tick();
    chk("hit_pulse_end", o_texel_valid, 1'b0);
    chk("hit_ready_back", o_tex_req_ready, 1'b1);
    chk("hit_no_mem_req2", o_mem_req_valid, 1'b0);
    // After invalidate the same request goes to memory again.
    inval();
    miss_req(tv[2]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
